// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage register hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int        NUM_REGS        = 16;
  localparam logic [3:0] REG_PC         = 4'd15;
  localparam int        WB_LAT_DEF      = 3;
  localparam int        FLUSH_DEPTH_DEF = 1;

  typedef struct packed {
    logic       valid;
    logic [3:0] addr;
  } sb_slot_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Decode issue controller: tracks in-flight register writes, stalls on RAW
// hazards, squashes young writes on flush and cross-checks writebacks.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int WB_LAT      = WB_LAT_DEF,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
  parameter bit WB_BYPASS   = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid_i,
  input  logic [3:0]       dec_r1_addr_i,
  input  logic             dec_r1_use_i,
  input  logic [3:0]       dec_r2_addr_i,
  input  logic             dec_r2_use_i,
  input  logic             dec_wr_en_i,
  input  logic [3:0]       dec_wr_addr_i,
  input  logic             flush_i,
  input  logic             wb_en_i,
  input  logic [3:0]       wb_addr_i,
  output logic             stall_o,
  output logic             issue_o,
  output logic [15:0]      busy_o,
  output logic             wb_mismatch_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // With a write-first register file the writeback-cycle slot is already visible.
  localparam int BUSY_TOP = WB_BYPASS ? WB_LAT - 2 : WB_LAT - 1;

  sb_slot_t            slot_q [WB_LAT];
  sb_slot_t            slot_d [WB_LAT];
  logic [NUM_REGS-1:0] busy;
  logic                stall;
  logic                issue;
  logic                mismatch_d;

  always_comb begin
    busy = '0;
    for (int k = 0; k <= BUSY_TOP; k++) begin
      if (slot_q[k].valid) begin
        busy[slot_q[k].addr] = 1'b1;
      end
    end
    busy[REG_PC] = 1'b0;
  end

  always_comb begin
    stall = dec_valid_i && !flush_i &&
            ((dec_r1_use_i && busy[dec_r1_addr_i]) ||
             (dec_r2_use_i && busy[dec_r2_addr_i]));
    issue = dec_valid_i && !stall && !flush_i;
  end

  // A flush squashes the FLUSH_DEPTH youngest in-flight writes as they shift.
  always_comb begin
    slot_d[0].valid = issue && dec_wr_en_i && (dec_wr_addr_i != REG_PC);
    slot_d[0].addr  = dec_wr_addr_i;
    for (int k = 1; k < WB_LAT; k++) begin
      slot_d[k] = slot_q[k-1];
      if (flush_i && (k <= FLUSH_DEPTH)) begin
        slot_d[k].valid = 1'b0;
      end
    end
  end

  assign mismatch_d = slot_q[WB_LAT-1].valid &&
                      !(wb_en_i && (wb_addr_i == slot_q[WB_LAT-1].addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < WB_LAT; k++) begin
        slot_q[k] <= '0;
      end
      wb_mismatch_o <= 1'b0;
      stall_cnt_o   <= '0;
    end else begin
      for (int k = 0; k < WB_LAT; k++) begin
        slot_q[k] <= slot_d[k];
      end
      wb_mismatch_o <= mismatch_d;
      if (stall && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

  assign busy_o  = busy;
  assign stall_o = stall;
  assign issue_o = issue;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic
// checked every cycle against an in-flight write list model.
module tb_hazard_scoreboard;

  localparam int WB_LAT      = 3;
  localparam int FLUSH_DEPTH = 1;
  localparam bit WB_BYPASS   = 1'b1;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
  localparam int VIS_AGE     = WB_BYPASS ? WB_LAT - 2 : WB_LAT - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             dec_valid_i;
  logic [3:0]       dec_r1_addr_i;
  logic             dec_r1_use_i;
  logic [3:0]       dec_r2_addr_i;
  logic             dec_r2_use_i;
  logic             dec_wr_en_i;
  logic [3:0]       dec_wr_addr_i;
  logic             flush_i;
  logic             wb_en_i;
  logic [3:0]       wb_addr_i;
  logic             stall_o;
  logic             issue_o;
  logic [15:0]      busy_o;
  logic             wb_mismatch_o;
  logic [CNT_W-1:0] stall_cnt_o;

  hazard_scoreboard #(
    .WB_LAT(WB_LAT), .FLUSH_DEPTH(FLUSH_DEPTH), .WB_BYPASS(WB_BYPASS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .dec_valid_i(dec_valid_i),
    .dec_r1_addr_i(dec_r1_addr_i), .dec_r1_use_i(dec_r1_use_i),
    .dec_r2_addr_i(dec_r2_addr_i), .dec_r2_use_i(dec_r2_use_i),
    .dec_wr_en_i(dec_wr_en_i), .dec_wr_addr_i(dec_wr_addr_i),
    .flush_i(flush_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
    .stall_o(stall_o), .issue_o(issue_o), .busy_o(busy_o),
    .wb_mismatch_o(wb_mismatch_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of in-flight writes, each with its age in cycles since issue.
  typedef struct {
    logic [3:0] r;
    int         age;
  } ent_t;

  ent_t q[$];
  ent_t nq[$];
  bit   m_mis   = 1'b0;
  int   m_cnt   = 0;
  bit   started = 1'b0;

  function automatic bit m_busy(input logic [3:0] r);
    if (r == 4'd15) return 1'b0;
    foreach (q[i]) if (q[i].r == r && q[i].age <= VIS_AGE) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return dec_valid_i && !flush_i &&
           ((dec_r1_use_i && m_busy(dec_r1_addr_i)) ||
            (dec_r2_use_i && m_busy(dec_r2_addr_i)));
  endfunction

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = m_busy(4'(r));
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_mis = 1'b0;
      m_cnt = 0;
    end else begin
      bit st;
      bit is;
      st = m_stall();
      is = dec_valid_i && !st && !flush_i;
      m_mis = 1'b0;
      foreach (q[i])
        if (q[i].age == WB_LAT - 1 && !(wb_en_i && wb_addr_i == q[i].r)) m_mis = 1'b1;
      if (st && m_cnt < CNT_MAX) m_cnt++;
      nq.delete();
      foreach (q[i])
        if (!(flush_i && q[i].age < FLUSH_DEPTH) && q[i].age + 1 < WB_LAT)
          nq.push_back('{q[i].r, q[i].age + 1});
      if (is && dec_wr_en_i && dec_wr_addr_i != 4'd15) nq.push_back('{dec_wr_addr_i, 0});
      q = nq;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy_o", 32'(busy_o), 32'(m_busy_vec()));
      chk("stall_o", 32'(stall_o), 32'(m_stall()));
      chk("issue_o", 32'(issue_o), 32'(dec_valid_i && !m_stall() && !flush_i));
      chk("wb_mismatch_o", 32'(wb_mismatch_o), 32'(m_mis));
      chk("stall_cnt_o", 32'(stall_cnt_o), 32'(m_cnt));
    end
  end

  task automatic idle_in();
    dec_valid_i = 0; dec_r1_addr_i = 0; dec_r1_use_i = 0;
    dec_r2_addr_i = 0; dec_r2_use_i = 0; dec_wr_en_i = 0; dec_wr_addr_i = 0;
    flush_i = 0; wb_en_i = 0; wb_addr_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      idle_in();
    end
  endtask

  task automatic issue_wr(input logic [3:0] rd);
    idle_in();
    dec_valid_i = 1; dec_wr_en_i = 1; dec_wr_addr_i = rd;
  endtask

  initial begin
    reset = 1;
    idle_in();
    cyc();
    cyc();
    reset = 0;
    #2;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_cnt", 32'(stall_cnt_o), 32'h0);

    // RAW on the previous instruction: two stall cycles with bypass.
    cyc(); issue_wr(4'd3); #2;
    chk("raw_issue_wr", 32'(issue_o), 32'h1);
    cyc(); idle_in(); dec_valid_i = 1; dec_r1_addr_i = 4'd3; dec_r1_use_i = 1; #2;
    chk("raw_stall1", 32'(stall_o), 32'h1);
    cyc(); #2;
    chk("raw_stall2", 32'(stall_o), 32'h1);
    cyc(); #2;
    chk("raw_release", 32'(stall_o), 32'h0);
    chk("raw_issue", 32'(issue_o), 32'h1);
    chk("raw_cnt", 32'(stall_cnt_o), 32'h2);

    // Independent stream R1..R8 reading R0: two-entry sliding busy window.
    idle_cycles(4);
    for (int i = 0; i < 8; i++) begin
      cyc(); issue_wr(4'(i + 1)); dec_r1_use_i = 1; #2;
      chk("ind_stall", 32'(stall_o), 32'h0);
      if (i >= 2) chk("ind_window", 32'(busy_o), (32'h1 << i) | (32'h1 << (i - 1)));
    end

    // Flush kills the R5 write issued the cycle before.
    idle_cycles(4);
    cyc(); issue_wr(4'd5);
    cyc(); issue_wr(4'd9); flush_i = 1; #2;
    chk("fl_busy_r5", 32'(busy_o), 32'h0020);
    chk("fl_stall", 32'(stall_o), 32'h0);
    chk("fl_issue", 32'(issue_o), 32'h0);
    cyc(); idle_in(); dec_valid_i = 1; dec_r1_addr_i = 4'd5; dec_r1_use_i = 1; #2;
    chk("fl_reader_stall", 32'(stall_o), 32'h0);
    chk("fl_busy_clear", 32'(busy_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle_in(); #2;
      chk("fl_no_mismatch", 32'(wb_mismatch_o), 32'h0);
    end

    // R15 writes are untracked; unused sources never stall.
    idle_cycles(4);
    cyc(); issue_wr(4'd15);
    cyc(); idle_in(); dec_valid_i = 1; dec_r1_addr_i = 4'd15; dec_r1_use_i = 1; #2;
    chk("pc_stall", 32'(stall_o), 32'h0);
    cyc(); issue_wr(4'd4);
    cyc(); idle_in(); dec_valid_i = 1; dec_r2_addr_i = 4'd4; dec_r2_use_i = 0;
    dec_r1_use_i = 1; #2;
    chk("r2_unused_busy", 32'(busy_o), 32'h0010);
    chk("r2_unused_stall", 32'(stall_o), 32'h0);

    // Writeback to R6 while R7 retires: one-cycle pulse one cycle later.
    idle_cycles(6);
    cyc(); issue_wr(4'd7);
    cyc(); idle_in();
    cyc(); idle_in();
    cyc(); idle_in(); wb_en_i = 1; wb_addr_i = 4'd6; #2;
    chk("mis_before", 32'(wb_mismatch_o), 32'h0);
    cyc(); idle_in(); #2;
    chk("mis_pulse", 32'(wb_mismatch_o), 32'h1);
    cyc(); #2;
    chk("mis_after", 32'(wb_mismatch_o), 32'h0);

    // Reset mid-run with two valid slots and a non-zero stall count.
    cyc(); issue_wr(4'd2);
    cyc(); issue_wr(4'd6);
    cyc(); idle_in(); reset = 1;
    cyc();
    cyc(); reset = 0; dec_valid_i = 1; dec_r1_addr_i = 4'd2; dec_r1_use_i = 1; #2;
    chk("mr_busy", 32'(busy_o), 32'h0);
    chk("mr_stall", 32'(stall_o), 32'h0);
    chk("mr_mismatch", 32'(wb_mismatch_o), 32'h0);
    chk("mr_cnt", 32'(stall_cnt_o), 32'h0);

    // Randomized traffic with a small register set to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      int v;
      cyc();
      reset         = ($urandom_range(0, 199) == 0);
      flush_i       = ($urandom_range(0, 9) == 0);
      dec_valid_i   = ($urandom_range(0, 3) != 0);
      v = $urandom_range(0, 8); dec_r1_addr_i = (v == 8) ? 4'd15 : 4'(v);
      v = $urandom_range(0, 8); dec_r2_addr_i = (v == 8) ? 4'd15 : 4'(v);
      v = $urandom_range(0, 8); dec_wr_addr_i = (v == 8) ? 4'd15 : 4'(v);
      dec_r1_use_i  = $urandom_range(0, 1);
      dec_r2_use_i  = $urandom_range(0, 1);
      dec_wr_en_i   = ($urandom_range(0, 3) != 0);
      wb_en_i       = ($urandom_range(0, 3) != 0);
      wb_addr_i     = 4'($urandom_range(0, 8));
      foreach (q[i])
        if (q[i].age == WB_LAT - 1 && $urandom_range(0, 9) < 7) wb_addr_i = q[i].r;
    end
    cyc(); idle_in(); reset = 1;
    cyc(); reset = 0;
    cyc();
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
